mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, SHALL set the RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the RAM data width.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be:
- iCE_CLK  in  1  system clock (12 MHz)
- rst  in  1  asynchronous active-high reset
- a_req  in  1  port A (monitor) access request
- a_we  in  1  port A write, 0 = read
- a_addr  in  ADDR_WIDTH  port A address
- a_wdata  in  DATA_WIDTH  port A write data
- a_gnt  out  1  port A request accepted, one-cycle pulse
- a_done  out  1  port A access complete, one-cycle pulse
- a_rdata  out  DATA_WIDTH  port A read data, valid with a_done
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: as port A, for port B (execution unit)
- ram_addr  out  ADDR_WIDTH  shared RAM address, used for both read and write
- ram_din  out  DATA_WIDTH  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DATA_WIDTH  RAM read data, one-cycle registered latency
- busy  out  1  high whenever state is not IDLE
- owner  out  1  0 = A, 1 = B; port of the current or most recent grant

Function
REQ-005 States SHALL be IDLE, ACCESS and RESP, with fixed transitions IDLE->ACCESS->RESP->IDLE.
REQ-006 In IDLE, with any req high at an edge, the block SHALL move to ACCESS at that edge.
REQ-007 At the same edge it SHALL pulse the winner's gnt and register ram_addr, ram_din and ram_we (= winner's we).
REQ-008 ram_we SHALL be high only during the ACCESS cycle.
REQ-009 On the ACCESS->RESP edge the block SHALL hold ram_addr and leave ram_we low.
REQ-010 On the RESP->IDLE edge it SHALL pulse the owner's done and load the owner's rdata from ram_dout.
- rdata is loaded for writes too; its value after a write is don't-care.
REQ-011 Latency SHALL be: req sampled at edge N; gnt at N; done and rdata at N+2. Peak throughput is one access per 3 cycles.
REQ-012 req, we, addr and wdata SHALL be sampled only in IDLE.
- A requester holds them until gnt and drops req in the cycle after gnt.
- A req still high on return to IDLE is a new request.
REQ-013 If both req are high in IDLE, port A SHALL win (fixed priority), except as given in REQ-020.
- The loser keeps req high and is served at the next IDLE.
REQ-014 a_rdata and b_rdata SHALL hold their value until that port's next done.
REQ-015 gnt and done of one port SHALL never be high in the same cycle as those of the other port.
REQ-016 ADDR_WIDTH is fixed for the design and SHALL never wrap or truncate addresses.

Reset
REQ-017 While rst is high:
- state = IDLE;
- gnt, done, ram_we, busy, owner = 0;
- ram_addr, ram_din, a_rdata, b_rdata = 0.
REQ-018 Reset asserted during ACCESS or RESP SHALL abort the transaction.
- No done pulse is issued afterwards.
- A write already strobed in ACCESS is not undone.
REQ-019 The round-robin pointer SHALL reset to "last granted = B".

Configuration
REQ-020 With macro MEM_ARBITER_RR_EN defined, simultaneous requests SHALL grant the port not granted last (round-robin).
- Single requests update the pointer too.
- Without the macro, fixed priority to port A and no pointer register.

Structure
REQ-021 The shared package puck_pkg SHALL hold the state encoding constants and the ADDR_WIDTH/DATA_WIDTH defaults.
REQ-022 Winner selection (fixed or round-robin) SHALL be in one sub-module, arb_pick.
- Inputs: a_req, b_req, last.
- Output: sel.
- Purely combinational.

Verification
REQ-023 The bench SHALL cover:
- A writes 0x5A to 0x010, then A reads 0x010 -> a_gnt at N, a_done at N+2, a_rdata = 0x5A; ram_we high exactly one cycle.
- A and B both request in the same IDLE cycle, repeated 4 times -> fixed: A,A,A,A with B starved while A holds req; RR: A,B,A,B.
- B writes 0xFF to 0x1FF, A reads 0x1FF -> a_rdata = 0xFF; b_rdata unchanged.
- rst pulsed during ACCESS of a B read -> no b_done; all outputs 0; next A request served normally.
- B holds req continuously -> b_gnt every 3 cycles; busy low exactly one cycle between accesses; owner = 1 throughout.

Source files
------------

// File: rtl/puck_pkg.sv
`default_nettype none
// ============================================================================
// Package : puck_pkg
// Brief   : Shared state encoding and width defaults for the memory arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
package puck_pkg;

  localparam int C_ADDR_WIDTH = 9;
  localparam int C_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// Module : arb_pick
// Brief  : Combinational winner select, 0 = port A, 1 = port B.
//          Round-robin on ties when MEM_ARBITER_RR_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module arb_pick (
  input  logic a_req,
  input  logic b_req,
  input  logic last,
  output logic sel
);

`ifdef MEM_ARBITER_RR_EN
  // On a tie, hand the grant to whichever port was not served last.
  assign sel = (a_req && b_req) ? ~last : b_req;
`else
  logic unused_last;
  assign unused_last = last;
  assign sel         = ~a_req & b_req;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Two-port arbiter onto one single-port RAM; IDLE->ACCESS->RESP.
//          Define MEM_ARBITER_RR_EN for round-robin tie breaking.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import puck_pkg::*;
#(
  parameter int ADDR_WIDTH = C_ADDR_WIDTH,
  parameter int DATA_WIDTH = C_DATA_WIDTH
) (
  input  logic                  iCE_CLK,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_done,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_done,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy,
  output logic                  owner
);

  state_t r_state;
  logic   w_sel;

`ifdef MEM_ARBITER_RR_EN
  logic r_last;

  arb_pick u_arb_pick (
    .a_req (a_req),
    .b_req (b_req),
    .last  (r_last),
    .sel   (w_sel)
  );
`else
  arb_pick u_arb_pick (
    .a_req (a_req),
    .b_req (b_req),
    .last  (1'b1),
    .sel   (w_sel)
  );
`endif

  always_ff @(posedge iCE_CLK or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      ram_we   <= 1'b0;
      busy     <= 1'b0;
      owner    <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_last   <= 1'b1;
`endif
    end else begin
      a_gnt  <= 1'b0;
      b_gnt  <= 1'b0;
      a_done <= 1'b0;
      b_done <= 1'b0;
      ram_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (a_req || b_req) begin
            r_state <= ACCESS;
            busy    <= 1'b1;
            owner   <= w_sel;
`ifdef MEM_ARBITER_RR_EN
            r_last  <= w_sel;
`endif
            if (w_sel) begin
              b_gnt    <= 1'b1;
              ram_addr <= b_addr;
              ram_din  <= b_wdata;
              ram_we   <= b_we;
            end else begin
              a_gnt    <= 1'b1;
              ram_addr <= a_addr;
              ram_din  <= a_wdata;
              ram_we   <= a_we;
            end
          end
        end
        // ram_addr is held so the registered RAM output matches this access.
        ACCESS: r_state <= RESP;
        RESP: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          if (owner) begin
            b_done  <= 1'b1;
            b_rdata <= ram_dout;
          end else begin
            a_done  <= 1'b1;
            a_rdata <= ram_dout;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
